// File: rtl/traffic_light_sequencer.sv
// rtl/traffic_light_sequencer.sv - timed traffic light phase sequencer with walk, night flash and emergency modes
//
// Purpose: consumes the 2-bit traffic mode (00 day, 01 night, 10 pedestrian,
// 11 emergency) and drives the NS/EW lamp heads plus the walk lamp. A single
// down-counter times every phase; green always exits through yellow and all-red.
//
// Optional feature macro: WALK_COUNTDOWN_EN (adds the walk_remaining output).
//
// Ports:
//   clk            in   1      system clock, rising edge
//   rst            in   1      synchronous reset, active-low (0 = reset)
//   mode           in   2      traffic mode, sampled every cycle
//   ns_light       out  3      NS head {R,Y,G}, one-hot or 000
//   ew_light       out  3      EW head {R,Y,G}, one-hot or 000
//   walk           out  1      pedestrian walk lamp
//   walk_remaining out  CNT_W  walk cycles left (only with WALK_COUNTDOWN_EN)

module traffic_light_sequencer #(
    parameter int GREEN_CYC  = 20,
    parameter int YELLOW_CYC = 4,
    parameter int ALLRED_CYC = 2,
    parameter int WALK_CYC   = 10,
    parameter int FLASH_HALF = 8,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    output logic [2:0]       ns_light,
    output logic [2:0]       ew_light,
`ifdef WALK_COUNTDOWN_EN
    output logic [CNT_W-1:0] walk_remaining,
`endif
    output logic             walk
);

    typedef enum logic [3:0] {
        S_NS_G  = 4'd0,
        S_NS_Y  = 4'd1,
        S_AR_A  = 4'd2,
        S_EW_G  = 4'd3,
        S_EW_Y  = 4'd4,
        S_AR_B  = 4'd5,
        S_WALK  = 4'd6,
        S_FLASH = 4'd7,
        S_EMG   = 4'd8
    } state_t;

    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] WALK_LD   = CNT_W'(WALK_CYC - 1);
    localparam logic [CNT_W-1:0] FLASH_LD  = CNT_W'(FLASH_HALF - 1);

    localparam logic [1:0] MODE_NIGHT = 2'b01;
    localparam logic [1:0] MODE_PED   = 2'b10;
    localparam logic [1:0] MODE_EMG   = 2'b11;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             blink_q, blink_d;
    logic             ped_served_q, ped_served_d;
    // Which green follows the current walk: 1 = EW_G (came from AR_A), 0 = NS_G.
    logic             walk_ret_q, walk_ret_d;
    logic [2:0]       ns_q, ns_d;
    logic [2:0]       ew_q, ew_d;
    logic             walk_q, walk_d;
    logic             ped_set;
    logic             cnt_zero;

    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        blink_d    = blink_q;
        walk_ret_d = walk_ret_q;
        ped_set    = 1'b0;

        case (state_q)
            S_NS_G, S_EW_G: begin
                // Emergency cuts a green short; yellow still runs its full time.
                if (mode == MODE_EMG || cnt_zero) begin
                    state_d = (state_q == S_NS_G) ? S_NS_Y : S_EW_Y;
                    cnt_d   = YELLOW_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_NS_Y, S_EW_Y: begin
                if (cnt_zero) begin
                    state_d = (state_q == S_NS_Y) ? S_AR_A : S_AR_B;
                    cnt_d   = ALLRED_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_AR_A, S_AR_B: begin
                if (cnt_zero) begin
                    if (mode == MODE_EMG) begin
                        state_d = S_EMG;
                        cnt_d   = '0;
                    end else if (mode == MODE_PED && !ped_served_q) begin
                        state_d    = S_WALK;
                        cnt_d      = WALK_LD;
                        ped_set    = 1'b1;
                        walk_ret_d = (state_q == S_AR_A);
                    end else if (mode == MODE_NIGHT) begin
                        state_d = S_FLASH;
                        cnt_d   = FLASH_LD;
                        blink_d = 1'b0;
                    end else begin
                        state_d = (state_q == S_AR_A) ? S_EW_G : S_NS_G;
                        cnt_d   = GREEN_LD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WALK: begin
                if (mode == MODE_EMG) begin
                    state_d = S_EMG;
                    cnt_d   = '0;
                end else if (cnt_zero) begin
                    state_d = walk_ret_q ? S_EW_G : S_NS_G;
                    cnt_d   = GREEN_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_FLASH: begin
                if (mode != MODE_NIGHT) begin
                    state_d = (mode == MODE_EMG) ? S_EMG : S_AR_B;
                    cnt_d   = (mode == MODE_EMG) ? '0 : ALLRED_LD;
                    blink_d = 1'b0;
                end else if (cnt_zero) begin
                    blink_d = ~blink_q;
                    cnt_d   = FLASH_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_EMG: begin
                if (mode != MODE_EMG) begin
                    state_d = S_AR_B;
                    cnt_d   = ALLRED_LD;
                end
            end
            default: begin
                state_d = S_AR_B;
                cnt_d   = ALLRED_LD;
                blink_d = 1'b0;
            end
        endcase

        // A held pedestrian request is honoured once; it re-arms when mode leaves 10.
        ped_served_d = (mode != MODE_PED) ? 1'b0 : (ped_served_q | ped_set);
    end

    // Lamp decode of the next state so the registered outputs line up with state_q.
    always_comb begin
        ns_d   = 3'b100;
        ew_d   = 3'b100;
        walk_d = 1'b0;
        case (state_d)
            S_NS_G:  ns_d = 3'b001;
            S_NS_Y:  ns_d = 3'b010;
            S_EW_G:  ew_d = 3'b001;
            S_EW_Y:  ew_d = 3'b010;
            S_WALK:  walk_d = 1'b1;
            S_FLASH: begin
                ns_d = blink_d ? 3'b000 : 3'b010;
                ew_d = blink_d ? 3'b000 : 3'b100;
            end
            default: begin
                ns_d = 3'b100;
                ew_d = 3'b100;
            end
        endcase
    end

`ifdef WALK_COUNTDOWN_EN
    logic [CNT_W-1:0] walk_rem_q, walk_rem_d;

    always_comb begin
        walk_rem_d = (state_d == S_WALK) ? (cnt_d + CNT_W'(1)) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            walk_rem_q <= '0;
        end else begin
            walk_rem_q <= walk_rem_d;
        end
    end

    assign walk_remaining = walk_rem_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_AR_B;
            cnt_q        <= ALLRED_LD;
            blink_q      <= 1'b0;
            ped_served_q <= 1'b0;
            walk_ret_q   <= 1'b0;
            ns_q         <= 3'b100;
            ew_q         <= 3'b100;
            walk_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            blink_q      <= blink_d;
            ped_served_q <= ped_served_d;
            walk_ret_q   <= walk_ret_d;
            ns_q         <= ns_d;
            ew_q         <= ew_d;
            walk_q       <= walk_d;
        end
    end

    assign ns_light = ns_q;
    assign ew_light = ew_q;
    assign walk     = walk_q;

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// tb/tb_traffic_light_sequencer.sv - self-checking bench for traffic_light_sequencer

module tb_traffic_light_sequencer;

    localparam int GREEN_CYC  = 20;
    localparam int YELLOW_CYC = 4;
    localparam int ALLRED_CYC = 2;
    localparam int WALK_CYC   = 10;
    localparam int FLASH_HALF = 8;
    localparam int CNT_W      = 8;

    // Phase names of the reference model.
    localparam int P_NSG = 0, P_NSY = 1, P_ARA = 2, P_EWG = 3, P_EWY = 4;
    localparam int P_ARB = 5, P_WALK = 6, P_FLASH = 7, P_EMG = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       walk;
`ifdef WALK_COUNTDOWN_EN
    logic [CNT_W-1:0] walk_remaining;
`endif

    always #5 clk = ~clk;

    traffic_light_sequencer #(
        .GREEN_CYC (GREEN_CYC),
        .YELLOW_CYC(YELLOW_CYC),
        .ALLRED_CYC(ALLRED_CYC),
        .WALK_CYC  (WALK_CYC),
        .FLASH_HALF(FLASH_HALF),
        .CNT_W     (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mode          (mode),
        .ns_light      (ns_light),
        .ew_light      (ew_light),
`ifdef WALK_COUNTDOWN_EN
        .walk_remaining(walk_remaining),
`endif
        .walk          (walk)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Reference model: current phase, cycles already spent in it, and side state.
    int m_ph, m_el, m_blink, m_ped, m_ret;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int dur(input int ph);
        case (ph)
            P_NSG, P_EWG: return GREEN_CYC;
            P_NSY, P_EWY: return YELLOW_CYC;
            P_ARA, P_ARB: return ALLRED_CYC;
            P_WALK:       return WALK_CYC;
            default:      return 0;
        endcase
    endfunction

    task automatic go(input int ph);
        m_ph = ph;
        m_el = 0;
    endtask

    task automatic model_step(input logic r, input int md);
        bit last;
        if (!r) begin
            go(P_ARB);
            m_blink = 0;
            m_ped   = 0;
            return;
        end
        last = (m_el + 1 >= dur(m_ph));
        case (m_ph)
            P_NSG:  if (md == 3 || last) go(P_NSY); else m_el++;
            P_EWG:  if (md == 3 || last) go(P_EWY); else m_el++;
            P_NSY:  if (last) go(P_ARA); else m_el++;
            P_EWY:  if (last) go(P_ARB); else m_el++;
            P_ARA, P_ARB: begin
                if (!last) m_el++;
                else if (md == 3) go(P_EMG);
                else if (md == 2 && !m_ped) begin
                    m_ped = 1;
                    m_ret = (m_ph == P_ARA) ? P_EWG : P_NSG;
                    go(P_WALK);
                end else if (md == 1) begin
                    m_blink = 0;
                    go(P_FLASH);
                end else go((m_ph == P_ARA) ? P_EWG : P_NSG);
            end
            P_WALK: if (md == 3) go(P_EMG); else if (last) go(m_ret); else m_el++;
            P_FLASH: begin
                if (md != 1) begin
                    m_blink = 0;
                    go((md == 3) ? P_EMG : P_ARB);
                end else begin
                    m_el++;
                    if (m_el == FLASH_HALF) begin
                        m_blink = 1 - m_blink;
                        m_el    = 0;
                    end
                end
            end
            default: if (md != 3) go(P_ARB);
        endcase
        if (md != 2) m_ped = 0;
    endtask

    task automatic compare();
        int ens, eew, ewk;
        ens = 4; eew = 4; ewk = 0;
        case (m_ph)
            P_NSG:   ens = 1;
            P_NSY:   ens = 2;
            P_EWG:   eew = 1;
            P_EWY:   eew = 2;
            P_WALK:  ewk = 1;
            P_FLASH: begin ens = m_blink ? 0 : 2; eew = m_blink ? 0 : 4; end
            default: ;
        endcase
        check("ns_light", int'(ns_light), ens);
        check("ew_light", int'(ew_light), eew);
        check("walk", int'(walk), ewk);
        check("no_conflict", int'((ns_light[1] | ns_light[0]) & (ew_light[1] | ew_light[0])), 0);
`ifdef WALK_COUNTDOWN_EN
        check("walk_remaining", int'(walk_remaining), (m_ph == P_WALK) ? WALK_CYC - m_el : 0);
`endif
    endtask

    task automatic step(input logic r, input int md);
        rst  = r;
        mode = 2'(md);
        @(posedge clk);
        model_step(r, md);
        @(negedge clk);
        cyc++;
        compare();
    endtask

    int lk[9]  = '{1, 2, 21, 22, 26, 28, 48, 52, 54};
    int lns[9] = '{4, 1, 1, 2, 4, 4, 4, 4, 1};
    int lew[9] = '{4, 4, 4, 4, 4, 1, 2, 4, 4};

    initial begin
        int wcnt;
        bit found;
        int md;
        logic r;

        m_ph = P_ARB; m_el = 0; m_blink = 0; m_ped = 0; m_ret = P_NSG;

        // Reset then the day ring, with hand-computed lamp values at phase edges.
        for (int i = 0; i < 3; i++) step(1'b0, 0);
        check("reset_ns", int'(ns_light), 4);
        check("reset_walk", int'(walk), 0);
        for (int k = 1; k <= 60; k++) begin
            step(1'b1, 0);
            for (int j = 0; j < 9; j++) begin
                if (lk[j] == k) begin
                    check("ring_ns", int'(ns_light), lns[j]);
                    check("ring_ew", int'(ew_light), lew[j]);
                end
            end
        end

        // Held pedestrian request: exactly one walk of WALK_CYC cycles.
        wcnt = 0;
        for (int i = 0; i < 200; i++) begin
            step(1'b1, 2);
            wcnt += int'(walk);
        end
        check("ped_once", wcnt, WALK_CYC);
        step(1'b1, 0);
        wcnt = 0;
        for (int i = 0; i < 150; i++) begin
            step(1'b1, 2);
            wcnt += int'(walk);
        end
        check("ped_rearm", wcnt, WALK_CYC);

        // Emergency hold and release back through AR_B into NS_G.
        for (int i = 0; i < 40; i++) step(1'b1, 3);
        check("emg_ns", int'(ns_light), 4);
        check("emg_ew", int'(ew_light), 4);
        step(1'b1, 0);
        step(1'b1, 0);
        check("emg_exit_arb", int'(ns_light), 4);
        step(1'b1, 0);
        check("emg_exit_nsg", int'(ns_light), 1);

        // Night flashing, then exit to AR_B next cycle.
        for (int i = 0; i < 100; i++) step(1'b1, 1);
        step(1'b1, 0);
        check("flash_exit", int'(ns_light), 4);

        // Reset in the middle of a yellow.
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            step(1'b1, 0);
            if (ns_light == 3'b010 || ew_light == 3'b010) found = 1;
        end
        check("found_yellow", int'(found), 1);
        step(1'b0, 0);
        check("midrst_ns", int'(ns_light), 4);
        step(1'b1, 0);
        check("midrst_arb", int'(ns_light), 4);
        step(1'b1, 0);
        check("midrst_nsg", int'(ns_light), 1);

        // Randomised modes and occasional resets.
        md = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(39) == 0) md = int'($urandom_range(3));
            r = ($urandom_range(399) != 0);
            step(r, md);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
